// File: rtl/vga_sync_out.sv
// VGA timing generator: divides the system clock down to the pixel rate,
// runs the horizontal/vertical raster counters and produces registered
// sync, colour and frame-tick outputs aligned one pixel period behind x/y.
module vga_sync_out #(
  parameter int CLK_DIV   = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [11:0] colour,
  output logic        hsync,
  output logic        vsync,
  output logic [11:0] vga,
  output logic [9:0]  x,
  output logic [9:0]  y,
  output logic        video_on,
  output logic        pixel_tick,
  output logic        frame_tick
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;
  localparam int DIV_W   = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [DIV_W-1:0] DIV_ONE  = DIV_W'(1);

  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_START = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_END   = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_START = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_END   = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic [9:0] V_FT     = 10'(V_DISPLAY - 1);

  logic [DIV_W-1:0] div_r;
  logic [9:0]       h_cnt_r;
  logic [9:0]       v_cnt_r;
  logic [9:0]       h_next_s;
  logic [9:0]       v_next_s;
  logic             pixel_tick_s;
  logic             video_on_s;
  logic             hsync_next_s;
  logic             vsync_next_s;
  logic             hsync_r;
  logic             vsync_r;
  logic [11:0]      vga_r;
  logic             frame_tick_r;

  assign pixel_tick_s = (div_r == DIV_LAST);
  assign video_on_s   = (h_cnt_r < H_VIS) && (v_cnt_r < V_VIS);

  // Clock divider: free-running 0..CLK_DIV-1, one pixel_tick per wrap.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      div_r <= '0;
    end else if (pixel_tick_s) begin
      div_r <= '0;
    end else begin
      div_r <= div_r + DIV_ONE;
    end
  end

  // Next raster position, including the single-step bottom-right wrap to (0,0).
  always_comb begin
    h_next_s = h_cnt_r;
    v_next_s = v_cnt_r;
    if (h_cnt_r == H_LAST) begin
      h_next_s = 10'd0;
      if (v_cnt_r == V_LAST) begin
        v_next_s = 10'd0;
      end else begin
        v_next_s = v_cnt_r + 10'd1;
      end
    end else begin
      h_next_s = h_cnt_r + 10'd1;
    end
  end

  // Sync pulse decode for the pixel currently addressed by the counters.
  always_comb begin
    hsync_next_s = 1'b1;
    vsync_next_s = 1'b1;
    if ((h_cnt_r >= HS_START) && (h_cnt_r <= HS_END)) begin
      hsync_next_s = 1'b0;
    end else begin
      hsync_next_s = 1'b1;
    end
    if ((v_cnt_r >= VS_START) && (v_cnt_r <= VS_END)) begin
      vsync_next_s = 1'b0;
    end else begin
      vsync_next_s = 1'b1;
    end
  end

  // Raster counters advance only on pixel ticks.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      h_cnt_r <= 10'd0;
      v_cnt_r <= 10'd0;
    end else if (pixel_tick_s) begin
      h_cnt_r <= h_next_s;
      v_cnt_r <= v_next_s;
    end else begin
      h_cnt_r <= h_cnt_r;
      v_cnt_r <= v_cnt_r;
    end
  end

  // Registered outputs: colour/sync latched once per pixel, frame pulse on entry to vblank.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      hsync_r      <= 1'b1;
      vsync_r      <= 1'b1;
      vga_r        <= 12'h000;
      frame_tick_r <= 1'b0;
    end else begin
      frame_tick_r <= pixel_tick_s && (h_cnt_r == H_LAST) && (v_cnt_r == V_FT);
      if (pixel_tick_s) begin
        hsync_r <= hsync_next_s;
        vsync_r <= vsync_next_s;
        vga_r   <= video_on_s ? colour : 12'h000;
      end else begin
        hsync_r <= hsync_r;
        vsync_r <= vsync_r;
        vga_r   <= vga_r;
      end
    end
  end

  assign hsync      = hsync_r;
  assign vsync      = vsync_r;
  assign vga        = vga_r;
  assign x          = h_cnt_r;
  assign y          = v_cnt_r;
  assign video_on   = video_on_s;
  assign pixel_tick = pixel_tick_s;
  assign frame_tick = frame_tick_r;

endmodule

// File: tb/tb_vga_sync_out.sv
// Directed bench for vga_sync_out. Horizontal timing is the full 800-pixel
// line; the frame is shortened to 6 lines (2 visible, 1 front porch, 2 sync,
// 1 back porch) so whole frames fit in a short run. vsync is low on y=3..4.
module tb_vga_sync_out;

  localparam int VD = 2;
  localparam int VT = 6;

  logic        clk;
  logic        reset;
  logic [11:0] colour;
  logic        hsync;
  logic        vsync;
  logic [11:0] vga;
  logic [9:0]  x;
  logic [9:0]  y;
  logic        video_on;
  logic        pixel_tick;
  logic        frame_tick;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  // reference model state
  int          ex, ey, ediv;
  logic [11:0] evga;
  logic        ehs, evs, eft;

  vga_sync_out #(
    .CLK_DIV(4), .H_DISPLAY(640), .H_FRONT(16), .H_SYNC(96), .H_BACK(48),
    .V_DISPLAY(2), .V_FRONT(1), .V_SYNC(2), .V_BACK(1)
  ) dut (
    .clk(clk), .reset(reset), .colour(colour), .hsync(hsync), .vsync(vsync),
    .vga(vga), .x(x), .y(y), .video_on(video_on), .pixel_tick(pixel_tick),
    .frame_tick(frame_tick)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic model_reset();
    ex = 0; ey = 0; ediv = 0;
    evga = 12'h000; ehs = 1'b1; evs = 1'b1; eft = 1'b0;
  endtask

  task automatic model_step();
    eft = 1'b0;
    if (ediv == 3) begin
      evga = (ex < 640 && ey < VD) ? colour : 12'h000;
      ehs  = !(ex >= 656 && ex <= 751);
      evs  = !(ey >= 3 && ey <= 4);
      eft  = (ex == 799 && ey == VD - 1);
      if (ex == 799) begin
        ex = 0;
        ey = (ey == VT - 1) ? 0 : ey + 1;
      end else begin
        ex = ex + 1;
      end
      ediv = 0;
    end else begin
      ediv = ediv + 1;
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    colour = 12'hFFF;
    repeat (3) step();
    n_cmp++; if (x !== 10'd0) begin n_bad++; $display("FAIL rst_x: got %0d want 0", x); end
    n_cmp++; if (y !== 10'd0) begin n_bad++; $display("FAIL rst_y: got %0d want 0", y); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync: got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync: got %b want 1", vsync); end
    n_cmp++; if (vga !== 12'h000) begin n_bad++; $display("FAIL rst_vga: got %h want 000", vga); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL rst_frame_tick: got %b want 0", frame_tick); end
    n_cmp++; if (pixel_tick !== 1'b0) begin n_bad++; $display("FAIL rst_pixel_tick: got %b want 0", pixel_tick); end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_cmp++; if (x !== 10'd0) begin n_bad++; $display("FAIL rel_x_c0: got %0d want 0", x); end
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (x !== 10'd0) begin n_bad++; $display("FAIL rel_x_c%0d: got %0d want 0", i, x); end
    end
    step();
    n_cmp++; if (x !== 10'd1) begin n_bad++; $display("FAIL rel_x_c4: got %0d want 1", x); end
    n_cmp++; if (y !== 10'd0) begin n_bad++; $display("FAIL rel_y_c4: got %0d want 0", y); end
    n_cmp++; if (vga !== 12'hFFF) begin n_bad++; $display("FAIL rel_vga: got %h want fff", vga); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL rel_hsync: got %b want 1", hsync); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL rel_vsync: got %b want 1", vsync); end
  endtask

  task automatic test_line();
    int   t656 = -100000;
    int   tfall = -100000;
    int   trise = -100000;
    int   tfall2 = -100000;
    logic prev_hs;
    logic vs_bad = 1'b0;
    prev_hs = hsync;
    for (int k = 0; k < 7000; k++) begin
      step();
      if (y == 10'd0 && vsync !== 1'b1) vs_bad = 1'b1;
      if (t656 < 0 && x == 10'd656) t656 = cyc;
      if (prev_hs === 1'b1 && hsync === 1'b0) begin
        if (tfall < 0) tfall = cyc;
        else begin
          tfall2 = cyc;
          break;
        end
      end
      if (prev_hs === 1'b0 && hsync === 1'b1 && trise < 0) trise = cyc;
      prev_hs = hsync;
    end
    n_cmp++; if (tfall - t656 !== 4) begin n_bad++; $display("FAIL hsync_delay: got %0d clks want 4", tfall - t656); end
    n_cmp++; if (trise - tfall !== 384) begin n_bad++; $display("FAIL hsync_width: got %0d clks want 384", trise - tfall); end
    n_cmp++; if (tfall2 - tfall !== 3200) begin n_bad++; $display("FAIL hsync_period: got %0d clks want 3200", tfall2 - tfall); end
    n_cmp++; if (vs_bad !== 1'b0) begin n_bad++; $display("FAIL vsync_line0: got low=%b want 0", vs_bad); end
  endtask

  task automatic test_frame();
    int   tf1 = -100000;
    int   tr1 = -100000;
    int   tf2 = -100000;
    int   pulses = 0;
    logic prev_vs;
    logic exp_ft;
    logic [9:0] px, py;
    prev_vs = vsync;
    px = x;
    py = y;
    for (int k = 0; k < 3 * 19200; k++) begin
      step();
      exp_ft = (px == 10'd799 && py == 10'(VD - 1) && x == 10'd0 && y == 10'(VD));
      n_cmp++; if (frame_tick !== exp_ft) begin n_bad++; $display("FAIL frame_tick @(%0d,%0d): got %b want %b", x, y, frame_tick, exp_ft); end
      if (tf1 >= 0 && frame_tick === 1'b1) pulses++;
      if (prev_vs === 1'b1 && vsync === 1'b0) begin
        if (tf1 < 0) tf1 = cyc;
        else begin
          tf2 = cyc;
          break;
        end
      end
      if (prev_vs === 1'b0 && vsync === 1'b1 && tf1 >= 0 && tr1 < 0) tr1 = cyc;
      prev_vs = vsync;
      px = x;
      py = y;
    end
    n_cmp++; if (tr1 - tf1 !== 6400) begin n_bad++; $display("FAIL vsync_width: got %0d clks want 6400", tr1 - tf1); end
    n_cmp++; if (tf2 - tf1 !== 19200) begin n_bad++; $display("FAIL vsync_period: got %0d clks want 19200", tf2 - tf1); end
    n_cmp++; if (pulses !== 1) begin n_bad++; $display("FAIL frame_tick_count: got %0d want 1", pulses); end
  endtask

  task automatic test_blanking();
    colour = 12'hABC;
    @(negedge clk);
    reset = 1'b1;
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    for (int k = 0; k < 4 * (800 * VT - 1); k++) begin
      step();
      model_step();
      n_cmp++; if (x !== 10'(ex)) begin n_bad++; $display("FAIL blank_x: got %0d want %0d", x, ex); end
      n_cmp++; if (y !== 10'(ey)) begin n_bad++; $display("FAIL blank_y: got %0d want %0d", y, ey); end
      n_cmp++; if (vga !== evga) begin n_bad++; $display("FAIL blank_vga @(%0d,%0d): got %h want %h", x, y, vga, evga); end
      n_cmp++; if (hsync !== ehs) begin n_bad++; $display("FAIL blank_hsync @(%0d,%0d): got %b want %b", x, y, hsync, ehs); end
      n_cmp++; if (vsync !== evs) begin n_bad++; $display("FAIL blank_vsync @(%0d,%0d): got %b want %b", x, y, vsync, evs); end
      n_cmp++; if (frame_tick !== eft) begin n_bad++; $display("FAIL blank_frame_tick @(%0d,%0d): got %b want %b", x, y, frame_tick, eft); end
      n_cmp++; if (video_on !== (ex < 640 && ey < VD)) begin n_bad++; $display("FAIL blank_video_on @(%0d,%0d): got %b", x, y, video_on); end
      n_cmp++; if (pixel_tick !== (ediv == 3)) begin n_bad++; $display("FAIL blank_pixel_tick: got %b want %b", pixel_tick, (ediv == 3)); end
    end
  endtask

  task automatic test_wrap();
    for (int i = 0; i < 3; i++) begin
      step();
      model_step();
      n_cmp++; if (x !== 10'd799 || y !== 10'd5) begin n_bad++; $display("FAIL wrap_hold: got (%0d,%0d) want (799,5)", x, y); end
    end
    step();
    model_step();
    n_cmp++; if (x !== 10'd0 || y !== 10'd0) begin n_bad++; $display("FAIL wrap_pos: got (%0d,%0d) want (0,0)", x, y); end
    n_cmp++; if (vsync !== 1'b1) begin n_bad++; $display("FAIL wrap_vsync: got %b want 1", vsync); end
    n_cmp++; if (hsync !== 1'b1) begin n_bad++; $display("FAIL wrap_hsync: got %b want 1", hsync); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL wrap_frame_tick: got %b want 0", frame_tick); end
    n_cmp++; if (vga !== 12'h000) begin n_bad++; $display("FAIL wrap_vga: got %h want 000", vga); end
  endtask

  task automatic test_async_reset();
    logic found = 1'b0;
    colour = 12'h5A5;
    for (int k = 0; k < 8000; k++) begin
      step();
      if (x == 10'd300 && y == 10'd1) begin
        found = 1'b1;
        break;
      end
    end
    n_cmp++; if (found !== 1'b1) begin n_bad++; $display("FAIL arst_reach: got found=%b want 1", found); end
    #1;
    reset = 1'b1;
    #1;
    n_cmp++; if (x !== 10'd0 || y !== 10'd0) begin n_bad++; $display("FAIL arst_pos: got (%0d,%0d) want (0,0)", x, y); end
    n_cmp++; if (hsync !== 1'b1 || vsync !== 1'b1) begin n_bad++; $display("FAIL arst_sync: got h=%b v=%b want 1/1", hsync, vsync); end
    n_cmp++; if (vga !== 12'h000) begin n_bad++; $display("FAIL arst_vga: got %h want 000", vga); end
    n_cmp++; if (frame_tick !== 1'b0) begin n_bad++; $display("FAIL arst_frame_tick: got %b want 0", frame_tick); end
    n_cmp++; if (pixel_tick !== 1'b0) begin n_bad++; $display("FAIL arst_pixel_tick: got %b want 0", pixel_tick); end
    step();
    step();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      step();
      n_cmp++; if (x !== 10'd0) begin n_bad++; $display("FAIL arst_rel_x_c%0d: got %0d want 0", i, x); end
    end
    step();
    n_cmp++; if (x !== 10'd1 || y !== 10'd0) begin n_bad++; $display("FAIL arst_rel_pos: got (%0d,%0d) want (1,0)", x, y); end
    n_cmp++; if (vga !== 12'h5A5) begin n_bad++; $display("FAIL arst_rel_vga: got %h want 5a5", vga); end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_blanking();
    test_wrap();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/vga_sync_out.md
VGA_SYNC_OUT -- requirements
Module: vga_sync_out

Interface
REQ-001 Parameter CLK_DIV, default 4: system clocks per pixel (100 MHz clk gives a 25 MHz pixel rate).
REQ-002 Parameters H_DISPLAY 640, H_FRONT 16, H_SYNC 96, H_BACK 48 (H_TOTAL = 800).
REQ-003 Parameters V_DISPLAY 480, V_FRONT 10, V_SYNC 2, V_BACK 33 (V_TOTAL = 525).
REQ-004 clk  in  1  system clock; every flop is clocked on its rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 colour  in  12  RGB444 pixel colour, computed by upstream logic from x and y.
REQ-007 hsync  out  1  horizontal sync, active low, registered.
REQ-008 vsync  out  1  vertical sync, active low, registered.
REQ-009 vga  out  12  RGB444 to the DAC, registered, forced to 0 while blanked.
REQ-010 x  out  10  current horizontal counter h_cnt, range 0..799.
REQ-011 y  out  10  current vertical counter v_cnt, range 0..524.
REQ-012 video_on  out  1  combinational: high when h_cnt < 640 and v_cnt < 480.
REQ-013 pixel_tick  out  1  combinational: high for one clk per pixel period.
REQ-014 frame_tick  out  1  registered: one-clk pulse per frame, used as the game-logic frame timebase.

Function
REQ-015 Divider div counts 0..CLK_DIV-1 every clk, wrapping to 0.
REQ-016 pixel_tick is high exactly while div == CLK_DIV-1.
REQ-017 h_cnt and v_cnt change only on clk edges where pixel_tick is high.
REQ-018 On such an edge, h_cnt increments; at 799 it wraps to 0 and v_cnt increments.
REQ-019 v_cnt wraps from 524 to 0 when h_cnt wraps at the same time.
REQ-020 The (799,524) -> (0,0) transition happens in a single tick.
REQ-021 x and y are driven directly from h_cnt and v_cnt with zero latency.
REQ-022 Sampling of colour:
- colour is sampled only on pixel_tick edges.
- This gives upstream CLK_DIV-1 clks of settling after x/y change, which covers a one-cycle ROM read.
REQ-023 On each pixel_tick edge:
- vga <= video_on ? colour : 12'h000
- hsync <= ~(656 <= h_cnt <= 751)
- vsync <= ~(490 <= v_cnt <= 491)
REQ-024 vga, hsync and vsync therefore lag x/y by one pixel period and stay mutually aligned.
REQ-025 Between pixel_tick edges, vga, hsync and vsync hold their values.
REQ-026 frame_tick is high for exactly the one clk cycle following the tick edge on which (h_cnt,v_cnt) becomes (0,480); it is low at all other times.
REQ-027 colour is ignored while video_on is low; a non-zero input never reaches vga during blanking.
REQ-028 Arithmetic:
- All counter compares are unsigned 10-bit.
- The div width is clog2(CLK_DIV), minimum 1 bit.

Reset
REQ-029 While reset is high, without waiting for a clk edge:
- div, h_cnt and v_cnt = 0
- hsync = 1, vsync = 1
- vga = 12'h000, frame_tick = 0
REQ-030 Reset asserted mid-line or mid-frame aborts the frame immediately.
REQ-031 After reset release:
- The first pixel_tick occurs in the CLK_DIV-th clk cycle after release.
- Timing restarts from (0,0) with no partial-pulse glitch on hsync or vsync.

Verification
REQ-032 Reset release, colour=12'hFFF:
- x stays 0 for 4 clks, then reads 1.
- hsync=1, vsync=1.
- After the first tick edge, vga=12'hFFF.
REQ-033 Line timing:
- hsync falls 4 clks after x reaches 656.
- hsync stays low for 384 clks.
- hsync period is 3200 clks.
- vsync stays high throughout line 0.
REQ-034 Frame timing:
- vsync is low for 6400 clks per frame.
- vsync period is 1,680,000 clks.
- frame_tick pulses exactly once per frame, one clk after y becomes 480.
REQ-035 Blanking, colour held at 12'hABC:
- vga = 12'h000 for every pixel period following x >= 640 or y >= 480.
- vga = 12'hABC for every pixel period following a visible (x,y).
REQ-036 Wrap-around:
- From (799,524), the next tick gives (0,0).
- vsync returns high.
- frame_tick stays low.
REQ-037 Async reset at x=300, y=100 between clk edges:
- All outputs take their reset values before the next clk edge.
- After release, counting restarts from (0,0).
